// File: rtl/munoc_master_bni_receiver.sv
// Master-side BNI receiver: reassembles response flits into AXI B beats and R beats,
// with link backpressure and a sticky protocol-error flag.
module munoc_master_bni_receiver #(
  parameter int BW_FLIT     = 8,
  parameter int BW_NODE_ID  = 4,
  parameter int BW_TID      = 4,
  parameter int BW_MAX_DATA = 64
) (
  input  logic                   clk,
  input  logic                   rstnn,
  input  logic                   link_valid,
  input  logic                   link_eom,
  input  logic                   link_eop,
  input  logic [BW_FLIT-1:0]     link_flit,
  output logic                   link_ready,
  output logic                   bvalid,
  input  logic                   bready,
  output logic [BW_TID-1:0]      bid,
  output logic [1:0]             bresp,
  output logic                   rvalid,
  input  logic                   rready,
  output logic [BW_TID-1:0]      rid,
  output logic [1:0]             rresp,
  output logic                   rlast,
  output logic [BW_MAX_DATA-1:0] rdata,
  output logic [1:0]             rsize,
  output logic [BW_NODE_ID-1:0]  node_id,
  output logic                   err
);

  localparam int W_HDR  = BW_NODE_ID + BW_TID + 4;
  localparam int N_HDR  = (W_HDR + BW_FLIT - 1) / BW_FLIT;
  localparam int N_DMAX = (BW_MAX_DATA + 3 + BW_FLIT - 1) / BW_FLIT;
  localparam int N_MAX  = (N_HDR > N_DMAX) ? N_HDR : N_DMAX;
  localparam int SRW    = (N_MAX - 1) * BW_FLIT;
  localparam int MW     = N_MAX * BW_FLIT;
  localparam int CW     = $clog2(N_MAX + 1);

  localparam logic [2:0] ST_HDR  = 3'd0;
  localparam logic [2:0] ST_BOUT = 3'd1;
  localparam logic [2:0] ST_RDAT = 3'd2;
  localparam logic [2:0] ST_ROUT = 3'd3;
  localparam logic [2:0] ST_DISC = 3'd4;

  logic [2:0]             state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [SRW-1:0]         sr_q, sr_d;
  logic                   err_q, err_d;
  logic [BW_NODE_ID-1:0]  node_id_q, node_id_d;
  logic                   bvalid_q, bvalid_d;
  logic [BW_TID-1:0]      bid_q, bid_d;
  logic [1:0]             bresp_q, bresp_d;
  logic                   rvalid_q, rvalid_d;
  logic [BW_TID-1:0]      rid_q, rid_d;
  logic [1:0]             rresp_q, rresp_d;
  logic                   rlast_q, rlast_d;
  logic [BW_MAX_DATA-1:0] rdata_q, rdata_d;
  logic [1:0]             rsize_q, rsize_d;

  // Only previous flits are stored; the flit on the link completes the message view.
  logic [MW-1:0]          msg_vec;
  logic [W_HDR-1:0]       hdr;
  logic [BW_NODE_ID-1:0]  hdr_node;
  logic [1:0]             hdr_type;
  logic [BW_TID-1:0]      hdr_tid;
  logic [1:0]             hdr_f;
  logic                   accept;

  assign msg_vec  = {sr_q, link_flit};
  assign hdr      = msg_vec[N_HDR*BW_FLIT-1 -: W_HDR];
  assign hdr_node = hdr[W_HDR-1 -: BW_NODE_ID];
  assign hdr_type = hdr[BW_TID+3 -: 2];
  assign hdr_tid  = hdr[BW_TID+1 -: BW_TID];
  assign hdr_f    = hdr[1:0];
  assign accept   = link_valid & link_ready;

  logic [3:0][BW_MAX_DATA-1:0] dat_d;
  logic [3:0][1:0]             dat_rresp;
  logic [3:0]                  dat_rlast;
  logic [3:0]                  size_ok;
  logic [3:0][CW-1:0]          nd_last;

  genvar gi, gb;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_size
      localparam int S  = 32 << gi;
      localparam int ND = (S + 3 + BW_FLIT - 1) / BW_FLIT;
      if (S <= BW_MAX_DATA) begin : g_on
        logic [S-1:0] rev;
        // Byte 0 travels in the MSB of D but lands in rdata[7:0].
        for (gb = 0; gb < S / 8; gb++) begin : g_byte
          assign rev[8*gb +: 8] = msg_vec[ND*BW_FLIT-4-8*gb -: 8];
        end
        assign dat_d[gi]     = BW_MAX_DATA'(rev);
        assign dat_rlast[gi] = msg_vec[ND*BW_FLIT-1];
        assign dat_rresp[gi] = msg_vec[ND*BW_FLIT-2 -: 2];
        assign size_ok[gi]   = 1'b1;
        assign nd_last[gi]   = CW'(ND - 1);
      end else begin : g_off
        assign dat_d[gi]     = '0;
        assign dat_rlast[gi] = 1'b0;
        assign dat_rresp[gi] = 2'b00;
        assign size_ok[gi]   = 1'b0;
        assign nd_last[gi]   = '0;
      end
    end
  endgenerate

  logic fault;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sr_d      = sr_q;
    err_d     = err_q;
    node_id_d = node_id_q;
    bvalid_d  = bvalid_q;
    bid_d     = bid_q;
    bresp_d   = bresp_q;
    rvalid_d  = rvalid_q;
    rid_d     = rid_q;
    rresp_d   = rresp_q;
    rlast_d   = rlast_q;
    rdata_d   = rdata_q;
    rsize_d   = rsize_q;
    fault     = 1'b0;
    case (state_q)
      ST_HDR: begin
        if (accept) begin
          sr_d = msg_vec[SRW-1:0];
          if (cnt_q != CW'(N_HDR - 1)) begin
            if (link_eom) fault = 1'b1;
            else          cnt_d = cnt_q + CW'(1);
          end else begin
            cnt_d     = '0;
            node_id_d = hdr_node;
            if (!link_eom) fault = 1'b1;
            if (hdr_type == 2'b01) begin
              if (!link_eop) fault = 1'b1;
            end else if (hdr_type == 2'b10) begin
              if (link_eop || !size_ok[hdr_f]) fault = 1'b1;
            end else begin
              fault = 1'b1;
            end
            if (!fault) begin
              if (hdr_type == 2'b01) begin
                bvalid_d = 1'b1;
                bid_d    = hdr_tid;
                bresp_d  = hdr_f;
                state_d  = ST_BOUT;
              end else begin
                rid_d   = hdr_tid;
                rsize_d = hdr_f;
                state_d = ST_RDAT;
              end
            end
          end
        end
      end
      ST_BOUT: begin
        if (bready) begin
          bvalid_d = 1'b0;
          state_d  = ST_HDR;
        end
      end
      ST_RDAT: begin
        if (accept) begin
          sr_d = msg_vec[SRW-1:0];
          if (cnt_q != nd_last[rsize_q]) begin
            if (link_eom) fault = 1'b1;
            else          cnt_d = cnt_q + CW'(1);
          end else begin
            cnt_d = '0;
            if (!link_eom || (dat_rlast[rsize_q] != link_eop)) begin
              fault = 1'b1;
            end else begin
              rvalid_d = 1'b1;
              rdata_d  = dat_d[rsize_q];
              rresp_d  = dat_rresp[rsize_q];
              rlast_d  = dat_rlast[rsize_q];
              state_d  = ST_ROUT;
            end
          end
        end
      end
      ST_ROUT: begin
        if (rready) begin
          rvalid_d = 1'b0;
          state_d  = rlast_q ? ST_HDR : ST_RDAT;
        end
      end
      ST_DISC: begin
        if (accept && link_eop) state_d = ST_HDR;
      end
      default: state_d = ST_HDR;
    endcase
    // A faulty flit that already closes the packet needs no discard phase.
    if (fault) begin
      err_d   = 1'b1;
      cnt_d   = '0;
      state_d = link_eop ? ST_HDR : ST_DISC;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstnn) begin
      state_q   <= ST_HDR;
      cnt_q     <= '0;
      sr_q      <= '0;
      err_q     <= 1'b0;
      node_id_q <= '0;
      bvalid_q  <= 1'b0;
      bid_q     <= '0;
      bresp_q   <= 2'b00;
      rvalid_q  <= 1'b0;
      rid_q     <= '0;
      rresp_q   <= 2'b00;
      rlast_q   <= 1'b0;
      rdata_q   <= '0;
      rsize_q   <= 2'b00;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sr_q      <= sr_d;
      err_q     <= err_d;
      node_id_q <= node_id_d;
      bvalid_q  <= bvalid_d;
      bid_q     <= bid_d;
      bresp_q   <= bresp_d;
      rvalid_q  <= rvalid_d;
      rid_q     <= rid_d;
      rresp_q   <= rresp_d;
      rlast_q   <= rlast_d;
      rdata_q   <= rdata_d;
      rsize_q   <= rsize_d;
    end
  end

  assign link_ready = (state_q == ST_HDR) || (state_q == ST_RDAT) || (state_q == ST_DISC);
  assign bvalid     = bvalid_q;
  assign bid        = bid_q;
  assign bresp      = bresp_q;
  assign rvalid     = rvalid_q;
  assign rid        = rid_q;
  assign rresp      = rresp_q;
  assign rlast      = rlast_q;
  assign rdata      = rdata_q;
  assign rsize      = rsize_q;
  assign node_id    = node_id_q;
  assign err        = err_q;

endmodule

// File: tb/tb_munoc_master_bni_receiver.sv
// Directed bench for munoc_master_bni_receiver: vector table of complete packets plus
// hand-written sequences for backpressure, bursts and mid-packet reset.
module tb_munoc_master_bni_receiver;

  logic        clk = 1'b0;
  logic        rstnn = 1'b0;
  logic        link_valid = 1'b0;
  logic        link_eom = 1'b0;
  logic        link_eop = 1'b0;
  logic [7:0]  link_flit = 8'h00;
  logic        link_ready;
  logic        bvalid;
  logic        bready = 1'b0;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        rvalid;
  logic        rready = 1'b0;
  logic [3:0]  rid;
  logic [1:0]  rresp;
  logic        rlast;
  logic [63:0] rdata;
  logic [1:0]  rsize;
  logic [3:0]  node_id;
  logic        err;

  munoc_master_bni_receiver #(
    .BW_FLIT(8), .BW_NODE_ID(4), .BW_TID(4), .BW_MAX_DATA(64)
  ) dut (
    .clk(clk), .rstnn(rstnn),
    .link_valid(link_valid), .link_eom(link_eom), .link_eop(link_eop),
    .link_flit(link_flit), .link_ready(link_ready),
    .bvalid(bvalid), .bready(bready), .bid(bid), .bresp(bresp),
    .rvalid(rvalid), .rready(rready), .rid(rid), .rresp(rresp), .rlast(rlast),
    .rdata(rdata), .rsize(rsize), .node_id(node_id), .err(err)
  );

  always #5 clk = ~clk;

  // kind: 0 = no output expected, 1 = B beat, 2 = R beat
  typedef struct packed {
    logic [3:0]  n;
    logic [95:0] flits;
    logic [11:0] eom;
    logic [11:0] eop;
    logic [1:0]  kind;
    logic [3:0]  id;
    logic [1:0]  resp;
    logic [63:0] data;
    logic        last;
    logic [1:0]  size;
    logic [3:0]  node;
    logic        err;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] f, input logic eom, input logic eop);
    int n = 0;
    @(negedge clk);
    while (!link_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!link_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL link_ready_wait: got 0 after 50 cycles, expected 1");
    end else begin
      link_valid = 1'b1;
      link_flit  = f;
      link_eom   = eom;
      link_eop   = eop;
      @(posedge clk);
      #1;
      link_valid = 1'b0;
      link_eom   = 1'b0;
      link_eop   = 1'b0;
    end
  endtask

  task automatic send_vec(input vec_t v);
    for (int i = 0; i < int'(v.n); i++)
      send(v.flits[(int'(v.n) - 1 - i) * 8 +: 8], v.eom[i], v.eop[i]);
  endtask

  task automatic take_b(input string tag);
    @(negedge clk);
    bready = 1'b1;
    @(posedge clk);
    #1;
    bready = 1'b0;
    chk({tag, " bvalid_after_hs"}, 64'(bvalid), 64'd0);
    chk({tag, " ready_after_hs"}, 64'(link_ready), 64'd1);
  endtask

  task automatic take_r(input string tag);
    @(negedge clk);
    rready = 1'b1;
    @(posedge clk);
    #1;
    rready = 1'b0;
    chk({tag, " rvalid_after_hs"}, 64'(rvalid), 64'd0);
    chk({tag, " ready_after_hs"}, 64'(link_ready), 64'd1);
  endtask

  function automatic vec_t mk(input int n, input logic [95:0] flits, input logic [11:0] eom,
                              input logic [11:0] eop, input int kind, input logic [3:0] id,
                              input logic [1:0] resp, input logic [63:0] data, input logic last,
                              input logic [1:0] size, input logic [3:0] node, input logic e);
    vec_t v;
    v.n = 4'(n); v.flits = flits; v.eom = eom; v.eop = eop; v.kind = 2'(kind);
    v.id = id; v.resp = resp; v.data = data; v.last = last; v.size = size;
    v.node = node; v.err = e;
    return v;
  endfunction

  vec_t tv[8];

  initial begin
    tv[0] = mk(2, 96'h3560, 12'b10, 12'b10, 1, 4'h5, 2'b10, 64'h0, 1'b0, 2'd0, 4'h3, 1'b0);
    tv[1] = mk(2, 96'hA710, 12'b10, 12'b10, 1, 4'hC, 2'b01, 64'h0, 1'b0, 2'd0, 4'hA, 1'b0);
    tv[2] = mk(7, 96'h3940_8886644220, 12'b1000010, 12'b1000000, 2, 4'h5, 2'b00,
               64'h0000_0000_1122_3344, 1'b1, 2'd0, 4'h3, 1'b0);
    tv[3] = mk(11, 96'h29D0_A020406080A0C0E100, 12'b100_0000_0010, 12'b100_0000_0000, 2, 4'h7,
               2'b01, 64'h0807_0605_0403_0201, 1'b1, 2'd1, 4'h2, 1'b0);
    tv[4] = mk(6, 96'h3D40_FFFFFFFF, 12'b100010, 12'b100000, 0, 4'h0, 2'b00, 64'h0, 1'b0,
               2'd0, 4'h3, 1'b1);
    tv[5] = mk(2, 96'h3560, 12'b10, 12'b10, 1, 4'h5, 2'b10, 64'h0, 1'b0, 2'd0, 4'h3, 1'b1);
    tv[6] = mk(7, 96'h3940_8886644220, 12'b1010010, 12'b1000000, 0, 4'h0, 2'b00, 64'h0, 1'b0,
               2'd0, 4'h3, 1'b1);
    tv[7] = mk(2, 96'hA710, 12'b10, 12'b10, 1, 4'hC, 2'b01, 64'h0, 1'b0, 2'd0, 4'hA, 1'b1);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst link_ready", 64'(link_ready), 64'd1);
    chk("rst bvalid", 64'(bvalid), 64'd0);
    chk("rst rvalid", 64'(rvalid), 64'd0);
    chk("rst err", 64'(err), 64'd0);
    chk("rst node_id", 64'(node_id), 64'd0);
    chk("rst rdata", rdata, 64'd0);
    chk("rst bid", 64'(bid), 64'd0);
    @(negedge clk);
    rstnn = 1'b1;

    // B packet with an idle gap between flits, then 3 cycles of bready=0
    send(8'h35, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    send(8'h60, 1'b1, 1'b1);
    chk("gap bvalid", 64'(bvalid), 64'd1);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      chk($sformatf("hold%0d bvalid", c), 64'(bvalid), 64'd1);
      chk($sformatf("hold%0d bid", c), 64'(bid), 64'h5);
      chk($sformatf("hold%0d bresp", c), 64'(bresp), 64'h2);
      chk($sformatf("hold%0d link_ready", c), 64'(link_ready), 64'd0);
    end
    chk("hold node_id", 64'(node_id), 64'h3);
    take_b("hold");
    $display("seq backpressure: done");

    // Two-beat read burst with rready held high
    rready = 1'b1;
    send(8'h39, 1'b0, 1'b0);
    send(8'h40, 1'b1, 1'b0);
    send(8'h15, 1'b0, 1'b0);
    send(8'h57, 1'b0, 1'b0);
    send(8'h79, 1'b0, 1'b0);
    send(8'h9B, 1'b0, 1'b0);
    send(8'hA0, 1'b1, 1'b0);
    chk("burst0 rvalid", 64'(rvalid), 64'd1);
    chk("burst0 rdata", rdata, 64'h0000_0000_DDCC_BBAA);
    chk("burst0 rlast", 64'(rlast), 64'd0);
    chk("burst0 rid", 64'(rid), 64'h5);
    chk("burst0 bubble", 64'(link_ready), 64'd0);
    @(posedge clk);
    #1;
    chk("burst0 rvalid_after_hs", 64'(rvalid), 64'd0);
    chk("burst0 ready_after_hs", 64'(link_ready), 64'd1);
    send(8'hE0, 1'b0, 1'b0);
    send(8'h00, 1'b0, 1'b0);
    send(8'h00, 1'b0, 1'b0);
    send(8'h00, 1'b0, 1'b0);
    send(8'h20, 1'b1, 1'b1);
    chk("burst1 rvalid", 64'(rvalid), 64'd1);
    chk("burst1 rdata", rdata, 64'h0000_0000_0100_0000);
    chk("burst1 rlast", 64'(rlast), 64'd1);
    chk("burst1 rresp", 64'(rresp), 64'h3);
    chk("burst1 bubble", 64'(link_ready), 64'd0);
    @(posedge clk);
    #1;
    chk("burst1 rvalid_after_hs", 64'(rvalid), 64'd0);
    chk("burst1 ready_after_hs", 64'(link_ready), 64'd1);
    rready = 1'b0;
    $display("seq burst: done");

    // Table of complete packets
    for (int i = 0; i < 8; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      send_vec(tv[i]);
      chk({tag, " err"}, 64'(err), 64'(tv[i].err));
      chk({tag, " node_id"}, 64'(node_id), 64'(tv[i].node));
      if (tv[i].kind == 2'd1) begin
        chk({tag, " bvalid"}, 64'(bvalid), 64'd1);
        chk({tag, " rvalid"}, 64'(rvalid), 64'd0);
        chk({tag, " bid"}, 64'(bid), 64'(tv[i].id));
        chk({tag, " bresp"}, 64'(bresp), 64'(tv[i].resp));
        chk({tag, " link_ready"}, 64'(link_ready), 64'd0);
        take_b(tag);
      end else if (tv[i].kind == 2'd2) begin
        chk({tag, " rvalid"}, 64'(rvalid), 64'd1);
        chk({tag, " bvalid"}, 64'(bvalid), 64'd0);
        chk({tag, " rid"}, 64'(rid), 64'(tv[i].id));
        chk({tag, " rresp"}, 64'(rresp), 64'(tv[i].resp));
        chk({tag, " rdata"}, rdata, tv[i].data);
        chk({tag, " rlast"}, 64'(rlast), 64'(tv[i].last));
        chk({tag, " rsize"}, 64'(rsize), 64'(tv[i].size));
        take_r(tag);
      end else begin
        chk({tag, " bvalid"}, 64'(bvalid), 64'd0);
        chk({tag, " rvalid"}, 64'(rvalid), 64'd0);
        chk({tag, " link_ready"}, 64'(link_ready), 64'd1);
      end
      $display("vec%0d: kind=%0d bid=%0h rid=%0h rdata=%0h err=%0b", i, tv[i].kind, bid, rid,
               rdata, err);
    end

    // Reset after three data flits, then a fresh B packet
    send(8'h39, 1'b0, 1'b0);
    send(8'h40, 1'b1, 1'b0);
    send(8'h88, 1'b0, 1'b0);
    send(8'h86, 1'b0, 1'b0);
    send(8'h64, 1'b0, 1'b0);
    @(negedge clk);
    rstnn = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst err", 64'(err), 64'd0);
    chk("midrst node_id", 64'(node_id), 64'd0);
    chk("midrst link_ready", 64'(link_ready), 64'd1);
    chk("midrst rvalid", 64'(rvalid), 64'd0);
    @(negedge clk);
    rstnn = 1'b1;
    send(8'h35, 1'b0, 1'b0);
    send(8'h60, 1'b1, 1'b1);
    chk("postrst bvalid", 64'(bvalid), 64'd1);
    chk("postrst bid", 64'(bid), 64'h5);
    chk("postrst bresp", 64'(bresp), 64'h2);
    chk("postrst node_id", 64'(node_id), 64'h3);
    chk("postrst err", 64'(err), 64'd0);
    take_b("postrst");
    $display("seq midreset: done");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
